cic_uart_streamer: RTL and testbench



---
 rtl/cic_uart_streamer.sv | 153 +++++++++++++++
 tb/tb_cic_uart_streamer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cic_uart_streamer.sv
// cic_uart_streamer
//   Captures 32-bit CIC decimator output samples into a small FIFO and sends
//   each one to the host as a 5-byte UART 8N1 frame: 0xA5, then the sample
//   MSB byte first. Samples that arrive while the FIFO is full are dropped,
//   and the sticky overflow flag is set.
//
// Ports
//   clk          system clock
//   rst          synchronous, active-high reset
//   sample_in    CIC output sample, qualified by sample_valid
//   sample_valid one-cycle pulse per sample
//   tx           registered UART serial output, idle high
//   busy         high while a frame is on the line (FSM not IDLE)
//   overflow     sticky drop flag, cleared only by rst
//   fifo_level   FIFO occupancy, 0..2**FIFO_AW
//
// Handshake: there is no back-pressure. A sample is accepted on any edge
//   where sample_valid=1 and the FIFO was not full at the start of that
//   cycle. Otherwise the sample is discarded.
module cic_uart_streamer #(
   parameter int CLK_DIV = 50,
   parameter int FIFO_AW = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [31:0]        sample_in,
   input  logic               sample_valid,
   output logic               tx,
   output logic               busy,
   output logic               overflow,
   output logic [FIFO_AW:0]   fifo_level
);

   localparam int DEPTH = 1 << FIFO_AW;
   localparam int BW    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t              state, state_n;
   logic [BW-1:0]       baud_cnt, baud_n;
   logic [2:0]          bit_idx, bit_n;
   logic [2:0]          byte_idx, byte_n;
   logic [39:0]         frame, frame_n;
   logic                tx_n;
   logic [7:0]          cur_byte;
   logic                baud_done;
   logic                push, pop, full;

   logic [31:0]         mem [DEPTH];
   logic [FIFO_AW-1:0]  wr_ptr, rd_ptr;

   assign full      = (fifo_level == (FIFO_AW+1)'(DEPTH));
   assign push      = sample_valid && !full;
   assign baud_done = (baud_cnt == BW'(CLK_DIV - 1));
   assign busy      = (state != IDLE);

   // Next-state logic. The baud counter restarts on every state entry, so
   // each START, DATA bit, and STOP lasts exactly CLK_DIV cycles.
   always_comb begin
      state_n  = state;
      baud_n   = baud_cnt + 1'b1;
      bit_n    = bit_idx;
      byte_n   = byte_idx;
      frame_n  = frame;
      pop      = 1'b0;
      case (state)
         IDLE: begin
            baud_n = '0;
            if (fifo_level != '0) begin
               pop     = 1'b1;
               frame_n = {8'hA5, mem[rd_ptr]};
               byte_n  = '0;
               state_n = START;
            end
         end
         START: begin
            if (baud_done) begin
               baud_n  = '0;
               bit_n   = '0;
               state_n = DATA;
            end
         end
         DATA: begin
            if (baud_done) begin
               baud_n = '0;
               if (bit_idx == 3'd7) state_n = STOP;
               else                 bit_n   = bit_idx + 3'd1;
            end
         end
         STOP: begin
            if (baud_done) begin
               baud_n = '0;
               if (byte_idx == 3'd4) begin
                  state_n = IDLE;
               end else begin
                  byte_n  = byte_idx + 3'd1;
                  frame_n = {frame[31:0], 8'h00};
                  state_n = START;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // tx is registered from the next-state view, so the line changes on the
   // same edge as the state does and has no path from sample_valid.
   always_comb begin
      cur_byte = frame_n[39:32];
      tx_n     = 1'b1;
      case (state_n)
         START:   tx_n = 1'b0;
         DATA:    tx_n = cur_byte[bit_n];
         default: tx_n = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         baud_cnt   <= '0;
         bit_idx    <= '0;
         byte_idx   <= '0;
         frame      <= '0;
         tx         <= 1'b1;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
         overflow   <= 1'b0;
      end else begin
         state    <= state_n;
         baud_cnt <= baud_n;
         bit_idx  <= bit_n;
         byte_idx <= byte_n;
         frame    <= frame_n;
         tx       <= tx_n;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   fifo_level <= fifo_level + 1'b1;
            2'b01:   fifo_level <= fifo_level - 1'b1;
            default: fifo_level <= fifo_level;
         endcase
         if (sample_valid && full) overflow <= 1'b1;
      end
   end

   // Storage needs no reset: contents are only read below the occupancy.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= sample_in;
   end

endmodule

// File: tb/tb_cic_uart_streamer.sv
// tb_cic_uart_streamer
//   Directed/randomized bench for cic_uart_streamer with CLK_DIV=4 and
//   FIFO_AW=2. A free-running UART receiver decodes tx into frames. The
//   expected frame list is built from the drop rule: the link takes one
//   sample immediately when idle, and the FIFO holds the next 2**FIFO_AW.
module tb_cic_uart_streamer;

   localparam int CLK_DIV = 4;
   localparam int FIFO_AW = 2;
   localparam int DEPTH   = 1 << FIFO_AW;
   localparam int FRAME   = 50 * CLK_DIV;

   logic              clk = 1'b0;
   logic              rst;
   logic [31:0]       sample_in;
   logic              sample_valid;
   logic              tx;
   logic              busy;
   logic              overflow;
   logic [FIFO_AW:0]  fifo_level;

   int checks = 0;
   int errors = 0;

   logic [31:0] exp_q[$];
   logic [31:0] rx_q[$];
   logic [7:0]  rx_hdr_q[$];
   int          frame_err = 0;
   bit          rx_abort  = 1'b0;

   cic_uart_streamer #(.CLK_DIV(CLK_DIV), .FIFO_AW(FIFO_AW)) dut (
      .clk          (clk),
      .rst          (rst),
      .sample_in    (sample_in),
      .sample_valid (sample_valid),
      .tx           (tx),
      .busy         (busy),
      .overflow     (overflow),
      .fifo_level   (fifo_level)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   // UART receiver: samples mid-bit on falling clock edges.
   initial begin : uart_rx
      logic [7:0]  b;
      logic [39:0] fr;
      logic        bad;
      int          nbytes;
      nbytes = 0;
      fr     = '0;
      forever begin
         @(negedge clk);
         if (rx_abort) begin
            nbytes   = 0;
            rx_abort = 1'b0;
         end
         if (tx !== 1'b0) continue;
         repeat (CLK_DIV / 2) @(negedge clk);
         bad = (tx !== 1'b0);
         for (int i = 0; i < 8; i++) begin
            repeat (CLK_DIV) @(negedge clk);
            b[i] = tx;
         end
         repeat (CLK_DIV) @(negedge clk);
         if (tx !== 1'b1) bad = 1'b1;
         if (rx_abort) begin
            nbytes   = 0;
            rx_abort = 1'b0;
            continue;
         end
         if (bad) frame_err++;
         fr = {fr[31:0], b};
         nbytes++;
         if (nbytes == 5) begin
            rx_hdr_q.push_back(fr[39:32]);
            rx_q.push_back(fr[31:0]);
            nbytes = 0;
         end
      end
   end

   // driver: burst of n consecutive valid cycles. The model keeps the first
   // sample (taken by the idle link) plus as many as the FIFO holds.
   task automatic push_burst(input int n, input logic [31:0] base);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         sample_in    = base + 32'(i) * 32'h0101_0101;
         sample_valid = 1'b1;
         if (i < DEPTH + 1) exp_q.push_back(sample_in);
      end
      @(negedge clk);
      sample_valid = 1'b0;
   endtask

   // scoreboard: wait for the link to drain, then compare in order
   task automatic check_frames(input string tag);
      int n;
      n = 0;
      while ((rx_q.size() < exp_q.size() || busy || fifo_level != '0) && n < 8000) begin
         @(posedge clk);
         n++;
      end
      repeat (2 * CLK_DIV) @(posedge clk);
      #1;
      check({tag, "_count"}, 40'(rx_q.size()), 40'(exp_q.size()));
      while (exp_q.size() > 0 && rx_q.size() > 0) begin
         check({tag, "_data"}, 40'(rx_q.pop_front()), 40'(exp_q.pop_front()));
         check({tag, "_hdr"}, 40'(rx_hdr_q.pop_front()), 40'h0A5);
      end
      check({tag, "_framing"}, 40'(frame_err), 40'd0);
      exp_q.delete();
      rx_q.delete();
      rx_hdr_q.delete();
   endtask

   task automatic count_busy(output int hi);
      hi = 1;
      for (int k = 0; k < 1000; k++) begin
         @(posedge clk);
         #1;
         if (!busy) break;
         hi++;
      end
   endtask

   initial begin : stimulus
      int          hi, lo;
      logic [31:0] s;

      rst          = 1'b1;
      sample_in    = '0;
      sample_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("rst_tx", 40'(tx), 40'd1);
      check("rst_busy", 40'(busy), 40'd0);
      check("rst_overflow", 40'(overflow), 40'd0);
      check("rst_level", 40'(fifo_level), 40'd0);

      // single sample
      @(negedge clk);
      sample_in    = 32'h1234_5678;
      sample_valid = 1'b1;
      exp_q.push_back(32'h1234_5678);
      @(posedge clk);
      #1;
      check("single_level_e0", 40'(fifo_level), 40'd1);
      check("single_busy_e0", 40'(busy), 40'd0);
      check("single_tx_e0", 40'(tx), 40'd1);
      @(negedge clk);
      sample_valid = 1'b0;
      @(posedge clk);
      #1;
      check("single_level_e1", 40'(fifo_level), 40'd0);
      check("single_busy_e1", 40'(busy), 40'd1);
      check("single_tx_e1", 40'(tx), 40'd0);
      count_busy(hi);
      check("single_busy_len", 40'(hi), 40'(FRAME));
      check_frames("single");

      // back-to-back: push/pop in the same cycle, one idle cycle between frames
      @(negedge clk);
      sample_in    = 32'h0000_0001;
      sample_valid = 1'b1;
      exp_q.push_back(sample_in);
      @(posedge clk);
      #1;
      check("b2b_level_e0", 40'(fifo_level), 40'd1);
      @(negedge clk);
      sample_in = 32'hFFFF_FFFF;
      exp_q.push_back(sample_in);
      @(posedge clk);
      #1;
      check("b2b_level_pushpop", 40'(fifo_level), 40'd1);
      check("b2b_busy_e1", 40'(busy), 40'd1);
      @(negedge clk);
      sample_valid = 1'b0;
      count_busy(hi);
      check("b2b_frame1_len", 40'(hi), 40'(FRAME));
      lo = 1;
      for (int k = 0; k < 1000; k++) begin
         @(posedge clk);
         #1;
         if (busy) break;
         lo++;
      end
      check("b2b_gap", 40'(lo), 40'd1);
      check("b2b_level_after_pop2", 40'(fifo_level), 40'd0);
      count_busy(hi);
      check("b2b_frame2_len", 40'(hi), 40'(FRAME));
      check_frames("b2b");

      // overflow: 6 consecutive samples, 6th dropped
      push_burst(6, $urandom);
      #1;
      check("ovf_flag", 40'(overflow), 40'd1);
      check("ovf_level", 40'(fifo_level), 40'(DEPTH));
      check_frames("ovf");
      check("ovf_sticky", 40'(overflow), 40'd1);

      @(negedge clk);
      rst = 1'b1;
      rx_abort = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst2_overflow", 40'(overflow), 40'd0);

      // pointer wrap: 20 paced samples, none dropped
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         s            = ($urandom & 32'hFFFF_FF00) | 32'(i);
         sample_in    = s;
         sample_valid = 1'b1;
         exp_q.push_back(s);
         @(negedge clk);
         sample_valid = 1'b0;
         repeat ($urandom_range(210, 230)) @(negedge clk);
      end
      check_frames("wrap");
      check("wrap_overflow", 40'(overflow), 40'd0);

      // mid-frame reset during data bits of byte 2
      push_burst(6, $urandom);
      repeat (85) @(negedge clk);
      check("mid_busy_before", 40'(busy), 40'd1);
      check("mid_overflow_before", 40'(overflow), 40'd1);
      rst      = 1'b1;
      rx_abort = 1'b1;
      exp_q.delete();
      @(posedge clk);
      #1;
      check("mid_tx", 40'(tx), 40'd1);
      check("mid_busy", 40'(busy), 40'd0);
      check("mid_level", 40'(fifo_level), 40'd0);
      check("mid_overflow", 40'(overflow), 40'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (60) @(negedge clk);
      check("mid_idle_busy", 40'(busy), 40'd0);
      rx_q.delete();
      rx_hdr_q.delete();
      frame_err = 0;
      s = $urandom;
      @(negedge clk);
      sample_in    = s;
      sample_valid = 1'b1;
      exp_q.push_back(s);
      @(negedge clk);
      sample_valid = 1'b0;
      check_frames("post_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
